// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types for the EX-stage hazard controller: FSM state codes and the forwarding-select bundle.
package ex_hazard_ctrl_pkg;

  typedef logic [1:0] hz_state_e;

  localparam hz_state_e HZ_RUN     = 2'd0;
  localparam hz_state_e HZ_LDSTALL = 2'd1;
  localparam hz_state_e HZ_MEMWAIT = 2'd2;

  typedef struct packed {
    logic ex_s1;
    logic ex_s2;
    logic me_s1;
    logic me_s2;
  } fw_sel_t;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX/MEM qualifiers in, forwarding/stall/flush controls out.
interface ex_hazard_ctrl_if #(
  parameter int RegAddrW = 5,
  parameter int CntW     = 32
);

  logic                iID_valid;
  logic [RegAddrW-1:0] iID_rs1_addr;
  logic [RegAddrW-1:0] iID_rs2_addr;
  logic                iID_rs1_used;
  logic                iID_rs2_used;
  logic                iEX_valid;
  logic                iEX_wr_en;
  logic                iEX_is_load;
  logic [RegAddrW-1:0] iEX_rd_addr;
  logic                iME_valid;
  logic                iME_wr_en;
  logic [RegAddrW-1:0] iME_rd_addr;
  logic                iRedirect;
  logic                iMemBusy;

  logic                oFwExS1_en;
  logic                oFwExS2_en;
  logic                oFwMeS1_en;
  logic                oFwMeS2_en;
  logic                oStallIF;
  logic                oStallID;
  logic                oBubbleEX;
  logic                oStallEX;
  logic                oFlushID;
  logic [CntW-1:0]     oStallCnt;
  logic [CntW-1:0]     oFlushCnt;

  modport master (
    output iID_valid, iID_rs1_addr, iID_rs2_addr, iID_rs1_used, iID_rs2_used,
    output iEX_valid, iEX_wr_en, iEX_is_load, iEX_rd_addr,
    output iME_valid, iME_wr_en, iME_rd_addr, iRedirect, iMemBusy,
    input  oFwExS1_en, oFwExS2_en, oFwMeS1_en, oFwMeS2_en,
    input  oStallIF, oStallID, oBubbleEX, oStallEX, oFlushID,
    input  oStallCnt, oFlushCnt
  );

  modport slave (
    input  iID_valid, iID_rs1_addr, iID_rs2_addr, iID_rs1_used, iID_rs2_used,
    input  iEX_valid, iEX_wr_en, iEX_is_load, iEX_rd_addr,
    input  iME_valid, iME_wr_en, iME_rd_addr, iRedirect, iMemBusy,
    output oFwExS1_en, oFwExS2_en, oFwMeS1_en, oFwMeS2_en,
    output oStallIF, oStallID, oBubbleEX, oStallEX, oFlushID,
    output oStallCnt, oFlushCnt
  );

endinterface

// File: rtl/ex_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         iClk,
  input  logic         nRst,
  input  logic         iInc,
  output logic [W-1:0] oCnt
);

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      oCnt <= '0;
    end else if (iInc && (oCnt != '1)) begin
      oCnt <= oCnt + 1'b1;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: registered forwarding selects, load-use bubble, memory freeze,
// redirect flush, and saturating stall/flush event counters.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int RegAddrW = 5,
  parameter int CntW     = 32
) (
  input logic             iClk,
  input logic             nRst,
  ex_hazard_ctrl_if.slave hz
);

  logic [RegAddrW-1:0] srcAddr [2];
  logic [1:0]          srcUsed;
  logic [1:0]          exHit;
  logic [1:0]          meHit;
  logic                exWrites;
  logic                meWrites;
  logic                loadUse;

  hz_state_e stateReg;
  hz_state_e stateNext;
  fw_sel_t   fwReg;
  fw_sel_t   fwNext;

  logic stallIF;
  logic stallID;
  logic stallEX;
  logic bubbleEX;
  logic flushID;

  assign srcAddr[0] = hz.iID_rs1_addr;
  assign srcAddr[1] = hz.iID_rs2_addr;
  assign srcUsed    = {hz.iID_rs2_used, hz.iID_rs1_used};

  // x0 is hard-wired zero, so a write to it never produces a forwardable value.
  assign exWrites = hz.iEX_valid & hz.iEX_wr_en & (hz.iEX_rd_addr != '0);
  assign meWrites = hz.iME_valid & hz.iME_wr_en & (hz.iME_rd_addr != '0);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gSrc
      assign exHit[gi] = srcUsed[gi] & exWrites & (srcAddr[gi] == hz.iEX_rd_addr);
      assign meHit[gi] = srcUsed[gi] & meWrites & (srcAddr[gi] == hz.iME_rd_addr) & ~exHit[gi];
    end
  endgenerate

  // Once the single bubble is in, the load has left EX; masking in LDSTALL keeps it to one.
  assign loadUse = hz.iID_valid & hz.iEX_is_load & (|exHit) & (stateReg != HZ_LDSTALL);

  always_comb begin
    stallIF   = 1'b0;
    stallID   = 1'b0;
    stallEX   = 1'b0;
    bubbleEX  = 1'b0;
    flushID   = 1'b0;
    stateNext = HZ_RUN;
    if (hz.iMemBusy) begin
      stallIF   = 1'b1;
      stallID   = 1'b1;
      stallEX   = 1'b1;
      stateNext = HZ_MEMWAIT;
    end else if (hz.iRedirect) begin
      flushID  = 1'b1;
      bubbleEX = 1'b1;
    end else if (loadUse) begin
      stallIF  = 1'b1;
      stallID  = 1'b1;
      bubbleEX = 1'b1;
      if (stateReg == HZ_RUN) begin
        stateNext = HZ_LDSTALL;
      end
    end
  end

  always_comb begin
    fwNext = fwReg;
    if (!hz.iMemBusy) begin
      if (bubbleEX | flushID | !hz.iID_valid) begin
        fwNext = '0;
      end else begin
        fwNext.ex_s1 = exHit[0];
        fwNext.ex_s2 = exHit[1];
        fwNext.me_s1 = meHit[0];
        fwNext.me_s2 = meHit[1];
      end
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      stateReg <= HZ_RUN;
      fwReg    <= '0;
    end else begin
      stateReg <= stateNext;
      fwReg    <= fwNext;
    end
  end

  assign hz.oFwExS1_en = fwReg.ex_s1;
  assign hz.oFwExS2_en = fwReg.ex_s2;
  assign hz.oFwMeS1_en = fwReg.me_s1;
  assign hz.oFwMeS2_en = fwReg.me_s2;
  assign hz.oStallIF   = stallIF;
  assign hz.oStallID   = stallID;
  assign hz.oStallEX   = stallEX;
  assign hz.oBubbleEX  = bubbleEX;
  assign hz.oFlushID   = flushID;

  sat_counter #(.W(CntW)) uStallCnt (
    .iClk (iClk),
    .nRst (nRst),
    .iInc (stallID),
    .oCnt (hz.oStallCnt)
  );

  sat_counter #(.W(CntW)) uFlushCnt (
    .iClk (iClk),
    .nRst (nRst),
    .iInc (flushID),
    .oCnt (hz.oFlushCnt)
  );

endmodule
